multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the MIPS core. A state machine sequences fetch, decode, execute, memory and write-back for the fixed opcode set. It drives the PC update path (`PCWre`, `PCSrc`) together with the instruction register, register file, ALU and data-memory controls. It sits beside the datapath, takes `opcode` from the instruction register and `zero` from the ALU, and gates every architectural write.

## Interface
- No parameters. Opcode, state and select encodings live in `ctrl_pkg`.
- `CLK  in  1`: single clock, rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `opcode  in  6`: instruction-register `[31:26]`, stable from ID onward.
- `zero  in  1`: ALU zero flag, sampled in EXE_BR.
- `PCWre  out  1`: PC register write enable.
- `PCSrc  out  2`: next-PC select.
  - 00: PC+4.
  - 01: PC+4+(imm<<2).
  - 10: rs.
  - 11: jump address.
- `IRWre  out  1`: instruction register load.
- `ExtSel  out  1`: 0 = zero-extend, 1 = sign-extend.
- `ALUSrcB  out  1`: 1 = extended immediate.
- `ALUOp  out  3`: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `RegDst  out  2`: 00 = $31, 01 = rt, 10 = rd.
- `RegWre  out  1`: register file write enable.
- `WrRegDSrc  out  1`: 0 = PC+4, 1 = DB bus.
- `mRD  out  1`: data memory read.
- `mWR  out  1`: data memory write.
- `DBDataSrc  out  1`: 0 = ALU result, 1 = memory data.
- `halted  out  1`: high in HALT.

## Operation
- Opcodes:
  - R-type ALU: ADD 000000, SUB 000001, AND 010000, SLT 100110.
  - Immediate: ADDIU 000010, ORI 010010.
  - Memory: SW 110000, LW 110001.
  - Branch: BEQ 110100, BNE 110101.
  - Jump: J 111000, JR 111001, JAL 111010.
  - HALT 111111.
  - Any other opcode is undefined.
- States: IF, ID, EXE_AL, WB_AL, EXE_BR, EXE_LS, MEM, WB_LD, HALT.
- Static fields are a pure function of `opcode`, in every state:
  - `ExtSel` = 0 only for ORI.
  - `ALUSrcB` = 1 for ADDIU, ORI, LW, SW.
  - `ALUOp`: SUB/BEQ/BNE sub; AND and; ORI or; SLT slt; all others add.
  - `RegDst`: R-type → 10; ADDIU/ORI/LW → 01; JAL → 00.
  - `WrRegDSrc` = 0 only for JAL.
- Gated outputs are 0 unless listed below.
- IF: `IRWre`=1 → ID.
- ID transitions:
  - J: `PCWre`=1, `PCSrc`=11 → IF.
  - JR: `PCWre`=1, `PCSrc`=10 → IF.
  - JAL: `RegWre`=1, `PCWre`=1, `PCSrc`=11 → IF.
  - BEQ/BNE → EXE_BR.
  - LW/SW → EXE_LS.
  - ADD/SUB/AND/SLT/ADDIU/ORI → EXE_AL.
  - HALT → HALT.
  - Undefined opcode: `PCWre`=1, `PCSrc`=00 → IF (acts as NOP).
- EXE_AL → WB_AL.
- WB_AL: `RegWre`=1, `DBDataSrc`=0, `PCWre`=1, `PCSrc`=00 → IF.
- EXE_BR: `PCWre`=1; `PCSrc`=01 if taken, else 00 → IF.
  - Taken = (BEQ & `zero`) | (BNE & !`zero`).
- EXE_LS → MEM.
- MEM:
  - SW: `mWR`=1, `PCWre`=1, `PCSrc`=00 → IF.
  - LW: `mRD`=1 → WB_LD.
- WB_LD: `mRD`=1, `RegWre`=1, `DBDataSrc`=1, `PCWre`=1, `PCSrc`=00 → IF.
- HALT: all gated outputs 0, `halted`=1. Stays in HALT until RST.

## Timing
- State register updates on the rising edge of `CLK`. Gated outputs are Mealy: combinational from state, `opcode` and `zero`, valid in the same cycle.
- `PCWre` is high exactly one cycle per retired instruction: the last cycle of that instruction.
- `IRWre` is high only in IF.
- `RegWre`, `mWR` and `PCWre` are never high in IF.
- CPI: J/JR/JAL/undefined 2; BEQ/BNE 3; ALU ops 4; SW 4; LW 5.
- Reset:
  - RST sampled high forces state to IF at the next edge.
  - While RST is high, all outputs, including static fields, are driven 0.
  - The first cycle after release is IF with `IRWre`=1.
- RST asserted mid-instruction (any state, including HALT) aborts the instruction. No partial writes occur after the reset cycle.
- `zero` is ignored outside EXE_BR. `opcode` changes outside ID/EXE/MEM/WB have no effect.

## Structure
- `ctrl_pkg`: opcode localparams, state encoding (4-bit), `PCSrc` codes, `ALUOp` codes, `RegDst` codes.
- One sub-module, `ctrl_decode`: combinational mapping from `opcode` to the static fields plus a class one-hot (alu, ls, br, jmp, halt, undef).
- The top level holds the state register and the gated-output logic.

## Test plan
- Reset then ADD (000000): states IF, ID, EXE_AL, WB_AL. `RegWre`=1 and `PCWre`=1 with `PCSrc`=00 only in the 4th cycle. `RegDst`=10, `ALUOp`=000.
- BEQ with `zero`=1 → EXE_BR gives `PCSrc`=01, `PCWre`=1. BNE with `zero`=1 → `PCSrc`=00. CPI is 3 in both cases.
- LW: 5 cycles. `mRD`=1 in MEM and WB_LD. In WB_LD, `DBDataSrc`=1 and `RegWre`=1. `ALUSrcB`=1, `ExtSel`=1.
- JAL: in ID, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0, `PCSrc`=11, `PCWre`=1. Next state is IF.
- HALT (111111): `halted`=1 and all enables 0 for 10+ cycles. RST high for one cycle → IF with `IRWre`=1.
- RST asserted in MEM of SW → no `mWR` pulse after the reset edge. Opcode 101010 (undefined) → 2-cycle NOP with `PCSrc`=00.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, state and select encodings shared by the multicycle control unit
package ctrl_pkg;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD, S_HALT
  } state_t;
  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;
  typedef struct packed {
    logic alu;
    logic ls;
    logic br;
    logic jmp;
    logic halt;
    logic undef;
  } op_class_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode to static datapath fields plus one-hot instruction class
// Ports: i_opcode in; o_ext_sel, o_alu_src_b, o_alu_op, o_reg_dst, o_wr_reg_d_src, o_cls out
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic       o_ext_sel,
  output logic       o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_reg_dst,
  output logic       o_wr_reg_d_src,
  output op_class_t  o_cls
);
  logic w_rtype, w_imm, w_mem, w_br, w_jmp, w_halt;
  always_comb begin
    w_rtype = i_opcode == OP_ADD || i_opcode == OP_SUB || i_opcode == OP_AND || i_opcode == OP_SLT;
    w_imm = i_opcode == OP_ADDIU || i_opcode == OP_ORI;
    w_mem = i_opcode == OP_SW || i_opcode == OP_LW;
    w_br = i_opcode == OP_BEQ || i_opcode == OP_BNE;
    w_jmp = i_opcode == OP_J || i_opcode == OP_JR || i_opcode == OP_JAL;
    w_halt = i_opcode == OP_HALT;
    o_ext_sel = i_opcode != OP_ORI;
    o_alu_src_b = w_imm || w_mem;
    o_alu_op = (i_opcode == OP_SUB || w_br) ? ALU_SUB :
               i_opcode == OP_AND ? ALU_AND :
               i_opcode == OP_ORI ? ALU_OR :
               i_opcode == OP_SLT ? ALU_SLT : ALU_ADD;
    o_reg_dst = w_rtype ? RD_RD : (w_imm || i_opcode == OP_LW) ? RD_RT : RD_RA;
    o_wr_reg_d_src = i_opcode != OP_JAL;
    o_cls = '{alu: w_rtype || w_imm, ls: w_mem, br: w_br, jmp: w_jmp, halt: w_halt,
              undef: !(w_rtype || w_imm || w_mem || w_br || w_jmp || w_halt)};
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM sequencing IF/ID/EXE/MEM/WB
// Ports: CLK, RST (sync, active-high), opcode, zero in; PC, IR, regfile, ALU and memory controls plus halted out
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic       RegWre,
  output logic       WrRegDSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       halted
);
  state_t r_state, w_next;
  op_class_t w_cls;
  logic w_ext_sel, w_alu_src_b, w_wr_reg_d_src;
  logic [2:0] w_alu_op;
  logic [1:0] w_reg_dst, w_pc_src;
  logic w_pc_wre, w_ir_wre, w_reg_wre, w_mrd, w_mwr, w_db_src, w_taken;
  ctrl_decode u_dec (
    .i_opcode      (opcode),
    .o_ext_sel     (w_ext_sel),
    .o_alu_src_b   (w_alu_src_b),
    .o_alu_op      (w_alu_op),
    .o_reg_dst     (w_reg_dst),
    .o_wr_reg_d_src(w_wr_reg_d_src),
    .o_cls         (w_cls)
  );
  always_ff @(posedge CLK)
    r_state <= RST ? S_IF : w_next;
  assign w_taken = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
  always_comb begin
    w_next = r_state;
    w_pc_wre = 1'b0;
    w_pc_src = PC_NEXT;
    w_ir_wre = 1'b0;
    w_reg_wre = 1'b0;
    w_mrd = 1'b0;
    w_mwr = 1'b0;
    w_db_src = 1'b0;
    case (r_state)
      S_IF: begin
        w_ir_wre = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        w_next = S_IF;
        if (w_cls.jmp) begin
          w_pc_wre = 1'b1;
          w_pc_src = opcode == OP_JR ? PC_RS : PC_JMP;
          w_reg_wre = opcode == OP_JAL;
        end else if (w_cls.br) w_next = S_EXE_BR;
        else if (w_cls.ls) w_next = S_EXE_LS;
        else if (w_cls.alu) w_next = S_EXE_AL;
        else if (w_cls.halt) w_next = S_HALT;
        else if (w_cls.undef) w_pc_wre = 1'b1;
      end
      S_EXE_AL: w_next = S_WB_AL;
      S_WB_AL: begin
        w_reg_wre = 1'b1;
        w_pc_wre = 1'b1;
        w_next = S_IF;
      end
      S_EXE_BR: begin
        w_pc_wre = 1'b1;
        w_pc_src = w_taken ? PC_BR : PC_NEXT;
        w_next = S_IF;
      end
      S_EXE_LS: w_next = S_MEM;
      S_MEM: begin
        w_mrd = opcode == OP_LW;
        w_mwr = opcode == OP_SW;
        w_pc_wre = opcode != OP_LW;
        w_next = opcode == OP_LW ? S_WB_LD : S_IF;
      end
      S_WB_LD: begin
        w_mrd = 1'b1;
        w_reg_wre = 1'b1;
        w_db_src = 1'b1;
        w_pc_wre = 1'b1;
        w_next = S_IF;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end
  // reset forces every output low, static fields included
  always_comb begin
    {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, DBDataSrc, halted} = RST ? 9'd0 :
      {w_pc_wre, w_pc_src, w_ir_wre, w_reg_wre, w_mrd, w_mwr, w_db_src, r_state == S_HALT};
    {ExtSel, ALUSrcB, ALUOp, RegDst, WrRegDSrc} = RST ? 8'd0 :
      {w_ext_sel, w_alu_src_b, w_alu_op, w_reg_dst, w_wr_reg_d_src};
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0;
  logic PCWre, IRWre, ExtSel, ALUSrcB, RegWre, WrRegDSrc, mRD, mWR, DBDataSrc, halted;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [8:0] g;
  logic [7:0] s;
  int n_cmp = 0;
  int n_bad = 0;
  // g = {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, DBDataSrc, halted}
  localparam logic [8:0] V_Z    = 9'b0_00_0_0_0_0_0_0;
  localparam logic [8:0] V_IF   = 9'b0_00_1_0_0_0_0_0;
  localparam logic [8:0] V_WBAL = 9'b1_00_0_1_0_0_0_0;
  localparam logic [8:0] V_BRT  = 9'b1_01_0_0_0_0_0_0;
  localparam logic [8:0] V_NEXT = 9'b1_00_0_0_0_0_0_0;
  localparam logic [8:0] V_MEML = 9'b0_00_0_0_1_0_0_0;
  localparam logic [8:0] V_WBLD = 9'b1_00_0_1_1_0_1_0;
  localparam logic [8:0] V_MEMS = 9'b1_00_0_0_0_1_0_0;
  localparam logic [8:0] V_JAL  = 9'b1_11_0_1_0_0_0_0;
  localparam logic [8:0] V_HALT = 9'b0_00_0_0_0_0_0_1;
  assign g = {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, DBDataSrc, halted};
  assign s = {ExtSel, ALUSrcB, ALUOp, RegDst, WrRegDSrc};
  always #5 clk = ~clk;
  multicycle_ctrl dut (
    .CLK(clk), .RST(RST), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .halted(halted)
  );
  task automatic cyc(input logic r, input logic [5:0] op, input logic z);
    @(negedge clk);
    RST = r;
    opcode = op;
    zero = z;
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 6'b000001, 1'b1);
      n_cmp++;
      if ({g, s} !== 17'd0) begin
        n_bad++;
        $display("FAIL reset c%0d: got %b/%b want all zero", i, g, s);
      end
    end
  endtask
  task automatic test_alu(input logic [5:0] op, input logic [7:0] es);
    logic [8:0] e [4] = '{V_IF, V_Z, V_Z, V_WBAL};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, op, 1'b0);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL alu %b c%0d: got %b want %b", op, i, g, e[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (s !== es) begin
          n_bad++;
          $display("FAIL alu_static %b: got %b want %b", op, s, es);
        end
      end
    end
  endtask
  task automatic test_branch(input logic [5:0] op, input logic z, input logic [8:0] ex);
    logic [8:0] e [3] = '{V_IF, V_Z, ex};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, op, i == 2 ? z : ~z);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL branch %b z%0d c%0d: got %b want %b", op, z, i, g, e[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (s !== 8'b1_0_001_00_1) begin
          n_bad++;
          $display("FAIL branch_static: got %b want 10001001", s);
        end
      end
    end
  endtask
  task automatic test_lw;
    logic [8:0] e [5] = '{V_IF, V_Z, V_Z, V_MEML, V_WBLD};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 6'b110001, 1'b0);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL lw c%0d: got %b want %b", i, g, e[i]);
      end
      if (i == 4) begin
        n_cmp++;
        if (s !== 8'b1_1_000_01_1) begin
          n_bad++;
          $display("FAIL lw_static: got %b want 11000011", s);
        end
      end
    end
  endtask
  task automatic test_sw;
    logic [8:0] e [4] = '{V_IF, V_Z, V_Z, V_MEMS};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 6'b110000, 1'b0);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL sw c%0d: got %b want %b", i, g, e[i]);
      end
    end
  endtask
  task automatic test_two(input logic [5:0] op, input logic [8:0] ex, input logic [7:0] es);
    logic [8:0] e [2] = '{V_IF, ex};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, op, 1'b0);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL two %b c%0d: got %b want %b", op, i, g, e[i]);
      end
    end
    n_cmp++;
    if (s !== es) begin
      n_bad++;
      $display("FAIL two_static %b: got %b want %b", op, s, es);
    end
  endtask
  task automatic test_sw_reset;
    logic [8:0] e [4] = '{V_IF, V_Z, V_Z, V_Z};
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 6'b110000, 1'b0);
      n_cmp++;
      if (g !== e[i]) begin
        n_bad++;
        $display("FAIL sw_reset c%0d: got %b want %b", i, g, e[i]);
      end
    end
  endtask
  task automatic test_halt;
    for (int i = 0; i < 14; i++) begin
      logic [8:0] ex;
      ex = i == 0 ? V_IF : i == 1 ? V_Z : i < 12 ? V_HALT : i == 12 ? V_Z : V_IF;
      cyc(i == 12, 6'b111111, 1'b0);
      n_cmp++;
      if (g !== ex) begin
        n_bad++;
        $display("FAIL halt c%0d: got %b want %b", i, g, ex);
      end
    end
  endtask
  initial begin
    test_reset();
    test_alu(6'b000000, 8'b1_0_000_10_1);
    test_alu(6'b010010, 8'b0_1_011_01_1);
    test_alu(6'b100110, 8'b1_0_100_10_1);
    test_branch(6'b110100, 1'b1, V_BRT);
    test_branch(6'b110101, 1'b1, V_NEXT);
    test_branch(6'b110101, 1'b0, V_BRT);
    test_branch(6'b110100, 1'b0, V_NEXT);
    test_lw();
    test_sw();
    test_two(6'b111010, V_JAL, 8'b1_0_000_00_0);
    test_two(6'b111001, 9'b1_10_0_0_0_0_0_0, 8'b1_0_000_00_1);
    test_sw_reset();
    test_two(6'b101010, V_NEXT, 8'b1_0_000_00_1);
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
